// File: rtl/sdram_cpu_slot_arbiter.sv
// Shares the SDRAM controller's single per-frame CPU access slot between N_REQ
// requesters, round-robin, tracking the controller's 24-cycle frame.
module sdram_cpu_slot_arbiter #(
  parameter int ADDR_DEPTH  = 23,
  parameter int N_REQ       = 3,
  parameter int LATCH_CYCLE = 23,
  parameter int DATA_CYCLE  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sync,
  input  logic                        ram_rdy,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            we,
  input  logic [N_REQ*ADDR_DEPTH-1:0] addr,
  input  logic [N_REQ*8-1:0]          wdata,
  output logic [N_REQ-1:0]            gnt,
  output logic [N_REQ-1:0]            done,
  output logic [7:0]                  rdata,
  output logic [ADDR_DEPTH-1:0]       cpu_addr,
  output logic [7:0]                  cpu_data_wr,
  output logic                        cpu_rd,
  output logic                        cpu_wr,
  input  logic [7:0]                  cpu_data_rd
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [4:0] FC_LAST = 5'd23;
  localparam logic [4:0] ARB_FC  = 5'(LATCH_CYCLE - 1);
  localparam logic [4:0] DATA_FC = 5'(DATA_CYCLE);
  localparam logic [IDX_W:0] NREQ_W = (IDX_W + 1)'(N_REQ);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ - 1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

  state_t state_q, state_d;
  logic [4:0] fc_q, fc_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] win_q, win_d;
  logic is_wr_q, is_wr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [7:0] rdata_q, rdata_d;
  logic [ADDR_DEPTH-1:0] cpu_addr_q, cpu_addr_d;
  logic [7:0] cpu_data_wr_q, cpu_data_wr_d;
  logic cpu_rd_q, cpu_rd_d;
  logic cpu_wr_q, cpu_wr_d;

  logic [2*N_REQ-1:0] req_dbl_s;
  logic [N_REQ-1:0] req_rot_s;
  logic [IDX_W-1:0] win_s;

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W:0] sum);
    logic [IDX_W:0] r;
    if (sum >= NREQ_W) begin
      r = sum - NREQ_W;
    end else begin
      r = sum;
    end
    return r[IDX_W-1:0];
  endfunction

  // Frame counter mirroring the controller's own.
  always_comb begin
    fc_d = fc_q;
    if (sync) begin
      fc_d = 5'd0;
    end else if (fc_q == FC_LAST) begin
      fc_d = 5'd0;
    end else begin
      fc_d = fc_q + 5'd1;
    end
  end

  // Round-robin pick: rotate so the pointer sits at bit 0, lowest set bit wins.
  always_comb begin
    req_dbl_s = {req, req};
    req_rot_s = req_dbl_s[ptr_q +: N_REQ];
    win_s     = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req_rot_s[j]) begin
        win_s = wrap_idx({1'b0, ptr_q} + (IDX_W + 1)'(j));
      end else begin
        win_s = win_s;
      end
    end
  end

  // Transaction FSM: next state and next values of all registered outputs.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    win_d         = win_q;
    is_wr_d       = is_wr_q;
    gnt_d         = gnt_q;
    done_d        = '0;
    rdata_d       = rdata_q;
    cpu_addr_d    = cpu_addr_q;
    cpu_data_wr_d = cpu_data_wr_q;
    cpu_rd_d      = 1'b0;
    cpu_wr_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((fc_q == ARB_FC) && !sync && ram_rdy && (|req)) begin
          win_d         = win_s;
          is_wr_d       = we[win_s];
          gnt_d         = ONE_HOT0 << win_s;
          cpu_addr_d    = addr[win_s*ADDR_DEPTH +: ADDR_DEPTH];
          cpu_data_wr_d = wdata[win_s*8 +: 8];
          cpu_rd_d      = ~we[win_s];
          cpu_wr_d      = we[win_s];
          state_d       = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // The strobe lives only in the latch cycle; a sync here aborts the slot.
        if (sync) begin
          gnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (sync) begin
          gnt_d   = '0;
          state_d = ST_IDLE;
        end else if (fc_q == DATA_FC) begin
          done_d  = gnt_q;
          state_d = ST_DONE;
          if (!is_wr_q) begin
            rdata_d = cpu_data_rd;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        gnt_d   = '0;
        ptr_d   = wrap_idx({1'b0, win_q} + (IDX_W + 1)'(1));
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      fc_q          <= 5'd0;
      ptr_q         <= '0;
      win_q         <= '0;
      is_wr_q       <= 1'b0;
      gnt_q         <= '0;
      done_q        <= '0;
      rdata_q       <= 8'd0;
      cpu_addr_q    <= '0;
      cpu_data_wr_q <= 8'd0;
      cpu_rd_q      <= 1'b0;
      cpu_wr_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      fc_q          <= fc_d;
      ptr_q         <= ptr_d;
      win_q         <= win_d;
      is_wr_q       <= is_wr_d;
      gnt_q         <= gnt_d;
      done_q        <= done_d;
      rdata_q       <= rdata_d;
      cpu_addr_q    <= cpu_addr_d;
      cpu_data_wr_q <= cpu_data_wr_d;
      cpu_rd_q      <= cpu_rd_d;
      cpu_wr_q      <= cpu_wr_d;
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign rdata       = rdata_q;
  assign cpu_addr    = cpu_addr_q;
  assign cpu_data_wr = cpu_data_wr_q;
  assign cpu_rd      = cpu_rd_q;
  assign cpu_wr      = cpu_wr_q;

endmodule

// File: tb/tb_sdram_cpu_slot_arbiter.sv
// Directed bench for sdram_cpu_slot_arbiter: a vector table of single
// transactions plus hand-written round-robin, abort, not-ready and reset sequences.
module tb_sdram_cpu_slot_arbiter;

  localparam int N  = 3;
  localparam int AD = 23;

  typedef struct {
    int           idx;
    bit           w;
    logic [AD-1:0] a;
    logic [7:0]   wd;
    logic [7:0]   rd;
    logic [7:0]   exp_rdata;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sync = 1'b0;
  logic ram_rdy = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] we = '0;
  logic [N*AD-1:0] addr = '0;
  logic [N*8-1:0] wdata = '0;
  logic [N-1:0] gnt, done;
  logic [7:0] rdata, cpu_data_wr, cpu_data_rd;
  logic [AD-1:0] cpu_addr;
  logic cpu_rd, cpu_wr;
  logic [7:0] rd_byte = 8'h00;

  int tb_fc;
  int errors = 0;
  int checks = 0;
  vec_t vecs[6];
  int rr_exp[4];

  sdram_cpu_slot_arbiter #(.ADDR_DEPTH(AD), .N_REQ(N), .LATCH_CYCLE(23), .DATA_CYCLE(8)) dut (
    .clk(clk), .rst_n(rst_n), .sync(sync), .ram_rdy(ram_rdy),
    .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .rdata(rdata),
    .cpu_addr(cpu_addr), .cpu_data_wr(cpu_data_wr),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_data_rd(cpu_data_rd)
  );

  always #5 clk = ~clk;

  // Reference frame counter, as the controller keeps it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_fc <= 0;
    else if (sync) tb_fc <= 0;
    else if (tb_fc == 23) tb_fc <= 0;
    else tb_fc <= tb_fc + 1;
  end

  // Controller read data is only meaningful in its data cycle.
  assign cpu_data_rd = (tb_fc == 8) ? rd_byte : 8'hEE;

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (!$onehot0(gnt) || !$onehot0(done)) begin
        errors++;
        $display("FAIL onehot: gnt=%b done=%b required one-hot or zero", gnt, done);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_fc(input int t);
    int i = 0;
    while (tb_fc != t && i < 30) begin
      @(negedge clk);
      i++;
    end
    if (tb_fc != t) begin
      checks++;
      errors++;
      $display("FAIL wait_fc: frame count %0d never reached %0d", tb_fc, t);
    end
  endtask

  task automatic wait_ev(input bit want_done, input int limit, input string name, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (want_done ? (|done) : (cpu_rd | cpu_wr)) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout after %0d cycles", name, limit);
    end
  endtask

  task automatic set_req(input int idx, input bit w, input logic [AD-1:0] a, input logic [7:0] d);
    we[idx] = w;
    addr[idx*AD +: AD] = a;
    wdata[idx*8 +: 8] = d;
    req[idx] = 1'b1;
  endtask

  task automatic expect_issue(input string tag, input int idx, input bit w,
                              input logic [AD-1:0] a, input logic [7:0] d);
    bit seen;
    wait_ev(1'b0, 80, {tag, "_issue"}, seen);
    if (seen) begin
      chk({tag, "_issue_fc"}, tb_fc, 23);
      chk({tag, "_cpu_rd"}, cpu_rd, !w);
      chk({tag, "_cpu_wr"}, cpu_wr, w);
      chk({tag, "_cpu_addr"}, cpu_addr, a);
      chk({tag, "_cpu_data_wr"}, cpu_data_wr, d);
      chk({tag, "_gnt"}, gnt, 1 << idx);
      @(negedge clk);
      chk({tag, "_strobe_drop"}, {cpu_rd, cpu_wr}, 0);
    end
  endtask

  task automatic expect_done(input string tag, input int idx, input logic [7:0] exp_rd);
    bit seen;
    wait_ev(1'b1, 60, {tag, "_done"}, seen);
    if (seen) begin
      chk({tag, "_done_fc"}, tb_fc, 9);
      chk({tag, "_done"}, done, 1 << idx);
      chk({tag, "_rdata"}, rdata, exp_rd);
      req = '0;
      @(negedge clk);
      chk({tag, "_done_drop"}, done, 0);
      chk({tag, "_gnt_clear"}, gnt, 0);
    end
    req = '0;
  endtask

  initial begin
    bit seen;
    int ndone;
    int nstrobe;
    int ncyc;

    vecs[0] = '{0, 1'b0, 23'h001234, 8'h00, 8'hA5, 8'hA5};
    vecs[1] = '{1, 1'b1, 23'h7FFFFF, 8'h3C, 8'h77, 8'hA5};
    vecs[2] = '{2, 1'b0, 23'h000000, 8'h99, 8'h5A, 8'h5A};
    vecs[3] = '{1, 1'b0, 23'h400001, 8'h01, 8'hFF, 8'hFF};
    vecs[4] = '{0, 1'b1, 23'h2AAAAA, 8'hC3, 8'h00, 8'hFF};
    vecs[5] = '{2, 1'b1, 23'h555555, 8'h81, 8'h42, 8'hFF};
    rr_exp = '{0, 1, 2, 0};

    // Reset state, with all three requesters already pending for round robin.
    ram_rdy = 1'b1;
    rd_byte = 8'h11;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, AD'(32'h100 + i), 8'h00);
    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_cpu_addr", cpu_addr, 0);
    chk("rst_cpu_data_wr", cpu_data_wr, 0);
    chk("rst_cpu_rd", cpu_rd, 0);
    chk("rst_cpu_wr", cpu_wr, 0);
    rst_n = 1'b1;

    // Round robin with everyone requesting continuously.
    for (int k = 0; k < 4; k++) begin
      wait_ev(1'b1, 60, "rr_done", seen);
      if (seen) begin
        chk("rr_done", done, 1 << rr_exp[k]);
        chk("rr_gnt", gnt, 1 << rr_exp[k]);
        chk("rr_fc", tb_fc, 9);
        chk("rr_rdata", rdata, 8'h11);
      end
    end
    req = '0;

    // Table of single transactions.
    for (int v = 0; v < 6; v++) begin
      wait_fc(5);
      rd_byte = vecs[v].rd;
      set_req(vecs[v].idx, vecs[v].w, vecs[v].a, vecs[v].wd);
      expect_issue("vec", vecs[v].idx, vecs[v].w, vecs[v].a, vecs[v].wd);
      expect_done("vec", vecs[v].idx, vecs[v].exp_rdata);
    end

    // Sync during WAIT aborts; the same request is reissued and completes.
    wait_fc(5);
    rd_byte = 8'h6D;
    set_req(0, 1'b0, 23'h0ABCDE, 8'h00);
    expect_issue("abort", 0, 1'b0, 23'h0ABCDE, 8'h00);
    wait_fc(3);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    chk("abort_gnt", gnt, 0);
    chk("abort_cpu_rd", cpu_rd, 0);
    ndone = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (|done) ndone++;
      if (cpu_rd | cpu_wr) begin
        seen = 1'b1;
        break;
      end
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_reissue_seen", seen, 1);
    chk("abort_reissue_fc", tb_fc, 23);
    chk("abort_reissue_gnt", gnt, 3'b001);
    expect_done("abort", 0, 8'h6D);

    // Not ready for three frames: nothing issues; issue follows ram_rdy.
    ram_rdy = 1'b0;
    rd_byte = 8'h3E;
    set_req(2, 1'b0, 23'h123456, 8'h00);
    nstrobe = 0;
    for (int i = 0; i < 72; i++) begin
      @(negedge clk);
      if (cpu_rd | cpu_wr) nstrobe++;
    end
    chk("notrdy_no_strobe", nstrobe, 0);
    chk("notrdy_no_gnt", gnt, 0);
    wait_fc(10);
    ram_rdy = 1'b1;
    expect_issue("notrdy", 2, 1'b0, 23'h123456, 8'h00);
    expect_done("notrdy", 2, 8'h3E);

    // Sync coincident with the arbitration edge suppresses that issue.
    wait_fc(5);
    rd_byte = 8'hB7;
    set_req(1, 1'b0, 23'h00BEEF, 8'h00);
    wait_fc(22);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    chk("sync_arb_no_strobe", {cpu_rd, cpu_wr}, 0);
    chk("sync_arb_no_gnt", gnt, 0);
    ncyc = 0;
    while (!(cpu_rd | cpu_wr) && ncyc < 40) begin
      @(negedge clk);
      ncyc++;
    end
    chk("sync_arb_delay", ncyc, 23);
    chk("sync_arb_gnt", gnt, 3'b010);
    expect_done("sync_arb", 1, 8'hB7);

    // Request raised right at the arbitration edge is eligible.
    wait_fc(22);
    rd_byte = 8'h24;
    set_req(2, 1'b0, 23'h000777, 8'h00);
    @(negedge clk);
    chk("late_req_strobe", cpu_rd, 1);
    chk("late_req_gnt", gnt, 3'b100);
    expect_done("late_req", 2, 8'h24);

    // Move the pointer to 1, then reset mid-transaction.
    wait_fc(5);
    rd_byte = 8'h55;
    set_req(0, 1'b0, 23'h000010, 8'h00);
    expect_issue("ptr1", 0, 1'b0, 23'h000010, 8'h00);
    expect_done("ptr1", 0, 8'h55);
    wait_fc(5);
    rd_byte = 8'h9C;
    set_req(0, 1'b0, 23'h0000A0, 8'h00);
    set_req(2, 1'b0, 23'h0000C2, 8'h00);
    expect_issue("mid", 2, 1'b0, 23'h0000C2, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_gnt", gnt, 0);
    chk("midrst_done", done, 0);
    chk("midrst_rdata", rdata, 0);
    chk("midrst_cpu_addr", cpu_addr, 0);
    chk("midrst_cpu_data_wr", cpu_data_wr, 0);
    chk("midrst_strobes", {cpu_rd, cpu_wr}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    expect_issue("post_rst", 0, 1'b0, 23'h0000A0, 8'h00);
    expect_done("post_rst", 0, 8'h9C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_cpu_slot_arbiter.md
Name: sdram_cpu_slot_arbiter

Overview:
Shares the single CPU-bank access slot of the NES SDRAM controller between N_REQ requesters (6502 CPU, cartridge loader, debug port).
- Tracks the controller's 24-cycle frame.
- Round-robin arbitrates pending requests once per frame.
- Drives the controller's cpu_* port in the latch window.
- Returns read data to the winner with a one-cycle done pulse.

Parameters:
ADDR_DEPTH, 23, width of SDRAM byte address per bank.
N_REQ, 3, number of requesters (2..8).
LATCH_CYCLE, 23, frame cycle in which the controller samples cpu_* inputs.
DATA_CYCLE, 8, frame cycle in which cpu_data_rd is valid.

Ports:
clk  in  1  controller clock (8x PPU clock)
rst_n  in  1  asynchronous active-low reset
sync  in  1  frame restart, same signal fed to the controller
ram_rdy  in  1  controller rdy; no issue while low
req  in  N_REQ  per-requester request, level, held until done
we  in  N_REQ  per-requester 1=write 0=read
addr  in  N_REQ*ADDR_DEPTH  packed addresses, requester i at [i*ADDR_DEPTH +: ADDR_DEPTH]
wdata  in  N_REQ*8  packed write bytes
gnt  out  N_REQ  one-hot owner of the current transaction
done  out  N_REQ  one-cycle completion pulse to the owner
rdata  out  8  read byte, valid with done, held until next done
cpu_addr  out  ADDR_DEPTH  to controller
cpu_data_wr  out  8  to controller
cpu_rd  out  1  to controller
cpu_wr  out  1  to controller
cpu_data_rd  in  8  from controller

Behaviour:
Reset (rst_n low, asynchronous):
- All outputs 0.
- Frame counter 0, FSM IDLE, round-robin pointer 0.

Frame counter fc (0..23):
- sync -> 0.
- Else 23 -> 0.
- Else +1.
- Mirrors the controller exactly.

FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Arbitration takes place on the edge ending fc==LATCH_CYCLE-1, if ram_rdy=1 and |req.
  - Winner is the first asserted req at or after the pointer, wrapping modulo N_REQ.
  - At that edge: load gnt, cpu_addr, cpu_data_wr; set cpu_rd=~we or cpu_wr=we for the winner; go to ISSUE.
- ISSUE:
  - cpu_rd/cpu_wr are high for exactly the LATCH_CYCLE cycle.
  - At the edge ending it, clear cpu_rd/cpu_wr and go to WAIT. cpu_addr and cpu_data_wr hold their values.
- WAIT:
  - At the edge ending fc==DATA_CYCLE, capture rdata<=cpu_data_rd (reads only; writes leave rdata unchanged).
  - At that same edge, pulse done[winner] and go to DONE.
- DONE:
  - done high for one cycle.
  - Pointer <= winner+1 (wraps to 0 past N_REQ-1).
  - gnt cleared; return to IDLE.
  - The next issue is at the earliest the next LATCH_CYCLE, so there is at most one transaction per frame.

Handshake:
- Requester keeps req, we, addr, wdata stable from assertion until it sees done.
- It may drop req the cycle after done, or keep it high to request again.
- A req dropped before done is a protocol violation; the arbiter does not check for it.

Latency:
- Req seen at fc<=22 completes with done in fc==DATA_CYCLE+1 of the next frame.
- Worst case is 24 + (N_REQ-1)*24 cycles of waiting for other requesters, plus issue-to-done latency.

Boundary cases:
- sync in ISSUE or WAIT: abort. Deassert cpu_rd/cpu_wr, clear gnt, return to IDLE, no done, pointer unchanged. The request is re-arbitrated (single-byte writes are idempotent).
- sync coincident with the arbitration edge: no issue; stay IDLE.
- ram_rdy low at the arbitration edge: stay IDLE.
- ram_rdy dropping mid-transaction is ignored; it only gates new issues.
- req asserted exactly at the arbitration edge is eligible.
- Only one requester pending: it wins every frame regardless of pointer.
- gnt and done are always one-hot or zero.

Test Plan:
1. Single read: ram_rdy=1; req[0] at fc=5, we=0, addr=0x001234; model drives cpu_data_rd=0xA5 at fc=8 -> cpu_rd=1 only at fc=23 with cpu_addr=0x001234; done[0] at next-frame fc=9; rdata=0xA5.
2. Write: req[1], we=1, addr=0x7FFFFF, wdata=0x3C -> cpu_wr=1 at fc=23 with cpu_data_wr=0x3C; done[1] at fc=9; rdata unchanged.
3. Round robin: req=3'b111 held continuously from reset -> completion order 0,1,2,0 over four frames; gnt one-hot each frame.
4. sync abort: sync at fc=3 of the WAIT frame -> no done; cpu_rd low; same requester reissued at the following fc=23 and completes normally.
5. Not ready: ram_rdy=0 with req[2] pending for 3 frames -> no cpu_rd/cpu_wr; after ram_rdy=1, issue at the next fc=23.
6. Reset mid-transaction: rst_n low during WAIT -> all outputs 0 immediately; after release, pending req restarts from pointer 0.
